// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: debounce FSM encoding, defaults
// and the channel ordering used on the internal raw/level vectors.
package input_conditioner_pkg;

  localparam int unsigned DebCyclesDefault = 16;
  localparam int unsigned CwDefault        = 8;

  localparam int NumChannels = 5;
  localparam int ChStart     = 0;
  localparam int ChA0        = 1;
  localparam int ChA1        = 2;
  localparam int ChB0        = 3;
  localparam int ChB1        = 4;

  typedef enum logic [1:0] {
    StStable0 = 2'd0,
    StPend1   = 2'd1,
    StStable1 = 2'd2,
    StPend0   = 2'd3
  } deb_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchronizer followed by a counting debounce FSM.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DebCyclesDefault,
  parameter int unsigned CW         = CwDefault
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  // The last pending count before acceptance; the next agreeing sample toggles the level.
  localparam logic [CW-1:0] CntLast = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          synced;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign synced = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StStable0: begin
        if (synced) begin
          state_d = StPend1;
          cnt_d   = CW'(1);
        end
      end
      StPend1: begin
        if (!synced) begin
          state_d = StStable0;
        end else if (cnt_q == CntLast) begin
          state_d = StStable1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StStable1: begin
        if (!synced) begin
          state_d = StPend0;
          cnt_d   = CW'(1);
        end
      end
      StPend0: begin
        if (synced) begin
          state_d = StStable1;
        end else if (cnt_q == CntLast) begin
          state_d = StStable0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StStable0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StStable0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pending states still present the previously accepted level.
  assign level = (state_q == StStable1) || (state_q == StPend0);

endmodule

// File: rtl/input_conditioner.sv
// Conditions the start button and cylinder limit sensors, derives the start pulse
// and a sticky plausibility fault for the downstream sequencer.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DebCyclesDefault,
  parameter int unsigned CW         = CwDefault
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_raw,
  input  logic a0_raw,
  input  logic a1_raw,
  input  logic b0_raw,
  input  logic b1_raw,
  input  logic fault_clr,
  output logic start,
  output logic start_pulse,
  output logic a0,
  output logic a1,
  output logic b0,
  output logic b1,
  output logic fault
);

  logic [NumChannels-1:0] raw_vec;
  logic [NumChannels-1:0] lvl_vec;

  assign raw_vec[ChStart] = start_raw;
  assign raw_vec[ChA0]    = a0_raw;
  assign raw_vec[ChA1]    = a1_raw;
  assign raw_vec[ChB0]    = b0_raw;
  assign raw_vec[ChB1]    = b1_raw;

  for (genvar i = 0; i < NumChannels; i++) begin : gen_ch
    debounce_channel #(
      .DEB_CYCLES(DEB_CYCLES),
      .CW        (CW)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_vec[i]),
      .level  (lvl_vec[i])
    );
  end

  assign start = lvl_vec[ChStart];
  assign a0    = lvl_vec[ChA0];
  assign a1    = lvl_vec[ChA1];
  assign b0    = lvl_vec[ChB0];
  assign b1    = lvl_vec[ChB1];

  logic start_prev_q, start_prev_d;
  logic pulse_q, pulse_d;
  logic fault_q, fault_d;
  logic fault_set;

  // Both end positions of one cylinder reported at once is physically impossible.
  assign fault_set = (a0 & a1) | (b0 & b1);

  always_comb begin
    start_prev_d = start;
    pulse_d      = start & ~start_prev_q;
    fault_d      = fault_set | (fault_q & ~fault_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      start_prev_q <= start_prev_d;
      pulse_q      <= pulse_d;
      fault_q      <= fault_d;
    end
  end

  assign start_pulse = pulse_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEB_CYCLES=4: vector table, directed corner
// sequences and randomized stimulus against a sample-history reference model.
module tb_input_conditioner;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_raw = 1'b0, a0_raw = 1'b0, a1_raw = 1'b0, b0_raw = 1'b0, b1_raw = 1'b0;
  logic fault_clr = 1'b0;
  logic start, start_pulse, a0, a1, b0, b1, fault;
  logic [6:0] dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .DEB_CYCLES(DEB),
    .CW        (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_raw  (start_raw),
    .a0_raw     (a0_raw),
    .a1_raw     (a1_raw),
    .b0_raw     (b0_raw),
    .b1_raw     (b1_raw),
    .fault_clr  (fault_clr),
    .start      (start),
    .start_pulse(start_pulse),
    .a0         (a0),
    .a1         (a1),
    .b0         (b0),
    .b1         (b1),
    .fault      (fault)
  );

  // Output vector: {fault, b1, b0, a1, a0, start_pulse, start}
  assign dout = {fault, b1, b0, a1, a0, start_pulse, start};

  // Reference model. Raw vector bits: {b1, b0, a1, a0, start}.
  logic [4:0] m_pipe[$];
  logic [4:0] m_hist[$];
  logic [4:0] m_lvl, m_lvl_old;
  logic       m_pulse, m_fault;

  function automatic logic [6:0] m_exp();
    return {m_fault, m_lvl[4:1], m_pulse, m_lvl[0]};
  endfunction

  task automatic model_reset();
    m_pipe.delete();
    m_pipe.push_back(5'd0);
    m_pipe.push_back(5'd0);
    m_hist.delete();
    m_lvl     = '0;
    m_lvl_old = '0;
    m_pulse   = 1'b0;
    m_fault   = 1'b0;
  endtask

  // A level flips once the last DEB samples seen by the debouncer all disagree with it.
  task automatic model_edge(input logic [4:0] raw, input logic clr);
    logic [4:0] seen, nxt;
    logic       all_diff;
    seen = m_pipe.pop_front();
    m_pipe.push_back(raw);
    m_hist.push_back(seen);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    nxt = m_lvl;
    for (int ch = 0; ch < 5; ch++) begin
      all_diff = (m_hist.size() == DEB);
      foreach (m_hist[j]) if (m_hist[j][ch] == m_lvl[ch]) all_diff = 1'b0;
      if (all_diff) nxt[ch] = ~m_lvl[ch];
    end
    m_fault   = (m_lvl[1] & m_lvl[2]) | (m_lvl[3] & m_lvl[4]) | (m_fault & ~clr);
    m_pulse   = m_lvl[0] & ~m_lvl_old[0];
    m_lvl_old = m_lvl;
    m_lvl     = nxt;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Called at a negedge; applies inputs, advances one rising edge, returns at next negedge.
  task automatic step(input logic [4:0] raw, input logic clr);
    {b1_raw, b0_raw, a1_raw, a0_raw, start_raw} = raw;
    fault_clr = clr;
    @(posedge clk);
    model_edge(raw, clr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] raw;
    logic       clr;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int rise_edge;
    logic [4:0] hold_val;
    int hold_cnt[5];

    // A0 held high from edge 1 rises after edge DEB+2; a 3-cycle B1 glitch is ignored.
    for (int i = 0; i < 20; i++) begin
      tbl[i].raw = 5'b00010 | ((i >= 7 && i <= 9) ? 5'b10000 : 5'b00000);
      tbl[i].clr = 1'b0;
      tbl[i].exp = (i + 1 >= DEB + 2) ? 7'b0000100 : 7'b0000000;
    end

    model_reset();
    @(negedge clk);
    check("reset_state", 32'(dout), 32'd0);
    do_reset();
    check("reset_release", 32'(dout), 32'd0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].raw, tbl[i].clr);
      check("tbl_a0_b1glitch", 32'(dout), 32'(tbl[i].exp));
    end

    // Bouncing start, then held: exactly one single-cycle pulse.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step((i < 8) ? {4'b0, ((i % 4) < 2)} : 5'b00001, 1'b0);
      check("bounce_model", 32'(dout), 32'(m_exp()));
      pulses += int'(start_pulse);
    end
    check("bounce_pulse_count", 32'(pulses), 32'd1);
    check("bounce_start_level", 32'(start), 32'd1);

    // Start held through reset yields one pulse after release.
    start_raw = 1'b1;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step(5'b00001, 1'b0);
      pulses += int'(start_pulse);
    end
    check("held_reset_pulses", 32'(pulses), 32'd1);

    // Sticky fault: set wins over clear, clear only once the condition is gone.
    do_reset();
    for (int i = 0; i < 8; i++) step(5'b00110, 1'b0);
    check("fault_set", 32'(fault), 32'd1);
    step(5'b00110, 1'b1);
    check("fault_clr_while_active", 32'(fault), 32'd1);
    for (int i = 0; i < 8; i++) step(5'b00010, 1'b0);
    check("fault_sticky", 32'(dout), 32'(m_exp()));
    check("fault_a1_dropped", 32'({fault, a1}), 32'b10);
    step(5'b00010, 1'b1);
    check("fault_cleared", 32'(fault), 32'd0);

    // Reset mid-debounce of A0 clears everything at once and discards the pending edge.
    do_reset();
    for (int i = 0; i < 8; i++) step(5'b11001, 1'b0);
    check("pre_reset_levels", 32'(dout), 32'(m_exp()));
    check("pre_reset_fault", 32'(fault), 32'd1);
    for (int i = 0; i < 4; i++) step(5'b11011, 1'b0);
    check("a0_pending", 32'(a0), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(dout), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rise_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      step(5'b11011, 1'b0);
      check("post_reset_model", 32'(dout), 32'(m_exp()));
      if (a0 && rise_edge == 0) rise_edge = i;
    end
    check("a0_rise_after_reset", 32'(rise_edge), 32'(DEB + 2));

    // Randomized hold lengths straddle the debounce threshold.
    do_reset();
    hold_val = '0;
    for (int ch = 0; ch < 5; ch++) hold_cnt[ch] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int ch = 0; ch < 5; ch++) begin
        if (hold_cnt[ch] == 0) begin
          hold_val[ch] = 1'($urandom_range(0, 1));
          hold_cnt[ch] = int'($urandom_range(1, 8));
        end
        hold_cnt[ch]--;
      end
      step(hold_val, ($urandom_range(0, 3) == 0));
      check("random", 32'(dout), 32'(m_exp()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, number of consecutive stable clock cycles required to accept a new input level; legal range 2..255.
REQ-002 SHALL have parameter CW, default 8, debounce counter width; SHALL satisfy 2^CW > DEB_CYCLES.
REQ-003 SHALL have port CLK input 1 system clock; all logic on rising edge.
REQ-004 SHALL have port RESET_N input 1 asynchronous, active-low reset.
REQ-005 SHALL have port START_RAW input 1 raw start push-button, asynchronous, bouncing.
REQ-006 SHALL have port A0_RAW, A1_RAW, B0_RAW, B1_RAW input 1 each raw cylinder limit sensors (A retracted/extended, B retracted/extended), asynchronous.
REQ-007 SHALL have port FAULT_CLR input 1 synchronous clear of the sticky fault flag.
REQ-008 SHALL have port START output 1 debounced start level.
REQ-009 SHALL have port START_PULSE output 1 single-cycle pulse on debounced start rising edge; feeds the sequencer slot start input.
REQ-010 SHALL have port A0, A1, B0, B1 output 1 each debounced sensor levels; feed the sequencer slot sensor inputs.
REQ-011 SHALL have port FAULT output 1 sticky sensor-plausibility fault.

Function
REQ-012 SHALL pass each of the 5 raw inputs through a 2-flop synchronizer before any other use.
REQ-013 SHALL debounce each channel independently with a 4-state FSM: STABLE0, PEND1, STABLE1, PEND0.
REQ-014 In STABLE0/STABLE1: synchronized value equal to the debounced output -> stay, counter 0; different -> go to PEND1/PEND0, counter 1.
REQ-015 In PEND1/PEND0: synchronized value returns to the old level -> back to STABLE0/STABLE1, counter 0; still different -> counter +1.
REQ-016 The debounced output SHALL toggle, and the FSM SHALL enter the new STABLE state, on the edge where the counter would reach DEB_CYCLES.
REQ-017 Latency: raw level stable from rising edge 1 onward -> debounced output changes after rising edge DEB_CYCLES+2.
REQ-018 Any glitch shorter than DEB_CYCLES synchronized cycles SHALL NOT change the output.
REQ-019 The counter SHALL never exceed DEB_CYCLES and SHALL never wrap.
REQ-020 START_PULSE SHALL be high for exactly one cycle, on the cycle after START goes 0->1; no pulse on 1->0.
REQ-021 START_PULSE SHALL not re-fire until START has been debounced low and then high again.
REQ-022 FAULT SHALL set on any cycle where debounced (A0 and A1) or (B0 and B1) is 1.
REQ-023 FAULT SHALL remain set until a cycle with FAULT_CLR=1 and no fault condition.
REQ-024 If FAULT_CLR and the fault condition are both true in the same cycle, set SHALL win.
REQ-025 FAULT SHALL not gate START_PULSE or the sensor outputs; the gating decision belongs to the sequencer.

Reset
REQ-026 RESET_N low SHALL asynchronously clear all synchronizer flops, counters and outputs (START, START_PULSE, A0, A1, B0, B1, FAULT = 0), and set all FSMs to STABLE0.
REQ-027 Reset asserted mid-debounce SHALL discard the pending transition.
REQ-028 Reset release SHALL be taken synchronously; first evaluation occurs on the first edge after deassertion.
REQ-029 A raw input held high through reset SHALL appear at the output DEB_CYCLES+2 edges after release.
REQ-030 A START held high through reset SHALL produce exactly one START_PULSE after release.

Structure
REQ-031 The FSM state encoding and the DEB_CYCLES default SHALL be placed in a shared package or include file used by the project top.
REQ-032 One sub-module, debounce_channel (sync + FSM + counter, parameters DEB_CYCLES and CW), SHALL be instantiated 5 times.
REQ-033 Edge detection and fault logic SHALL sit in input_conditioner.

Verification
REQ-034 DEB_CYCLES=4, A0_RAW 0->1 held -> A0 rises after edge 6, not earlier.
REQ-035 START_RAW bounces 1,0,1,0 (2 cycles each) then held 1 -> one START_PULSE, 1 cycle wide, START stays 1.
REQ-036 B1_RAW 3-cycle glitch with DEB_CYCLES=4 -> B1 stays 0, no FAULT.
REQ-037 A0 and A1 raw both 1 -> FAULT=1 after both debounce. FAULT_CLR while both are still 1 -> FAULT stays 1. Drop A1, debounce, then FAULT_CLR -> FAULT=0.
REQ-038 RESET_N pulsed low while A0 is in PEND1 -> all outputs 0 immediately; A0 rises DEB_CYCLES+2 edges after release.
